// File: rtl/timer_counter_module.sv
// timer_counter_module: memory-mapped countdown timer with interrupt.
// Registers by Addr[3:2]: 00 CTRL {IM, Mode[1:0], Enable}, 01 PRESET,
// 10 COUNT (read-only), 11 reserved (reads 0).
// Build option TIMER_AUTORELOAD_EN: when defined, Mode[0]=1 selects
// auto-reload with a one-cycle IRQ pulse. When undefined, the mode bits are
// not stored, read as 0, and every expiry behaves as one-shot.
//
// state  | meaning
// IDLE   | waiting for Enable
// LOAD   | COUNT <- PRESET
// CNT    | counting down; Enable=0 returns to IDLE with COUNT held
// INT    | expiry: raise irq_pending, one-shot clears Enable
module timer_counter_module (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_enable;
  logic        r_im;
  logic        r_pending;
  logic [31:0] r_preset;
  logic [31:0] r_count;

  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_load;
  logic        w_dec;
  logic        w_expire;
  logic        w_int;
  logic        w_auto;
  logic [1:0]  w_mode_rd;
  logic        w_unused_addr;

  assign w_wr_ctrl     = WE & (Addr[3:2] == 2'b00);
  assign w_wr_preset   = WE & (Addr[3:2] == 2'b01);
  assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};

`ifdef TIMER_AUTORELOAD_EN
  logic [1:0] r_mode;

  // Mode bits are stored only when auto-reload is built in
  always_ff @(posedge clk) begin
    if (reset)
      r_mode <= 2'b00;
    else if (w_wr_ctrl)
      r_mode <= Din[2:1];
  end

  assign w_auto    = r_mode[0];
  assign w_mode_rd = r_mode;
`else
  assign w_auto    = 1'b0;
  assign w_mode_rd = 2'b00;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_enable) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_CNT;
      S_CNT: begin
        if (!r_enable)
          w_state_nxt = S_IDLE;
        else if (r_count <= 32'd1)
          w_state_nxt = S_INT;
      end
      S_INT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_expire = 1'b0;
    w_int    = 1'b0;
    case (r_state)
      S_LOAD: w_load = 1'b1;
      S_CNT: begin
        if (r_enable) begin
          if (r_count > 32'd1)
            w_dec = 1'b1;
          else
            w_expire = 1'b1;
        end
      end
      S_INT:   w_int = 1'b1;
      default: ;
    endcase
  end

  // CTRL Enable/IM; a CPU write on the expiry edge overrides the auto-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable <= 1'b0;
      r_im     <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_enable <= Din[0];
      r_im     <= Din[3];
    end else if (w_int && !w_auto) begin
      r_enable <= 1'b0;
    end
  end

  // PRESET register; only sampled into COUNT at LOAD
  always_ff @(posedge clk) begin
    if (reset)
      r_preset <= 32'd0;
    else if (w_wr_preset)
      r_preset <= Din;
  end

  // COUNT saturates at 0, so PRESET=0 expires like PRESET=1
  always_ff @(posedge clk) begin
    if (reset)
      r_count <= 32'd0;
    else if (w_load)
      r_count <= r_preset;
    else if (w_dec)
      r_count <= r_count - 32'd1;
    else if (w_expire)
      r_count <= 32'd0;
  end

  // Pending flag: set on expiry, cleared by CTRL/PRESET write, self-clears in auto-reload
  always_ff @(posedge clk) begin
    if (reset)
      r_pending <= 1'b0;
    else if (w_int)
      r_pending <= 1'b1;
    else if (w_wr_ctrl || w_wr_preset)
      r_pending <= 1'b0;
    else if (w_auto && r_pending)
      r_pending <= 1'b0;
  end

  assign IRQ = r_im & r_pending;

  // Zero-latency read mux
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'b00:   Dout = {28'd0, r_im, w_mode_rd, r_enable};
      2'b01:   Dout = r_preset;
      2'b10:   Dout = r_count;
      default: Dout = 32'd0;
    endcase
  end

endmodule
